controlador_memoria: RTL and testbench

- Initiator-side sequencer for the data memory block `memoriaBloco`.
- Accepts single read/write requests from the processor datapath over a valid/ready handshake.
- Drives the memory port signals `memEndereco`, `memValor`, `escreverMemoria` and `lerMemoria`, waits a configurable number of cycles, then captures `saida`.
- Returns the result over a valid/accept response handshake, and rejects out-of-range addresses without touching memory.

---
 rtl/controlador_memoria.sv | 98 +++++++++
 tb/tb_controlador_memoria.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_memoria.sv
// controlador_memoria: request/response sequencer driving the memoriaBloco data memory port,
// with configurable read latency and out-of-range address rejection.
module controlador_memoria #(
    parameter int LATENCIA     = 1,
    parameter int PROFUNDIDADE = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValido,
    input  logic        reqEscrita,
    input  logic [31:0] reqEndereco,
    input  logic [31:0] reqDado,
    output logic        reqPronto,
    output logic        respValido,
    input  logic        respAceito,
    output logic [31:0] respDado,
    output logic        respErro,
    output logic [31:0] memEndereco,
    output logic [31:0] memValor,
    output logic        escreverMemoria,
    output logic        lerMemoria,
    input  logic [31:0] saida
);
    localparam int CW = (LATENCIA < 2) ? 1 : $clog2(LATENCIA + 1);

    typedef enum logic [1:0] {OCIOSO, ESCRITA, LEITURA, RESPOSTA} estado_t;

    estado_t       estado;
    logic [CW-1:0] contador;
    logic          fora;

    assign fora = reqEndereco >= 32'(PROFUNDIDADE);

    // reqPronto is only raised by a clock edge, so acceptance also requires it to be high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado          <= OCIOSO;
            contador        <= '0;
            reqPronto       <= 1'b0;
            respValido      <= 1'b0;
            respDado        <= '0;
            respErro        <= 1'b0;
            memEndereco     <= '0;
            memValor        <= '0;
            escreverMemoria <= 1'b0;
            lerMemoria      <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (reqPronto && reqValido) begin
                        reqPronto   <= 1'b0;
                        memEndereco <= reqEndereco;
                        memValor    <= reqDado;
                        if (fora) begin
                            estado     <= RESPOSTA;
                            respValido <= 1'b1;
                            respErro   <= 1'b1;
                            respDado   <= '0;
                        end else if (reqEscrita) begin
                            estado          <= ESCRITA;
                            escreverMemoria <= 1'b1;
                        end else begin
                            estado     <= LEITURA;
                            lerMemoria <= 1'b1;
                            contador   <= CW'(LATENCIA);
                        end
                    end else begin
                        reqPronto <= 1'b1;
                    end
                end
                ESCRITA: begin
                    escreverMemoria <= 1'b0;
                    estado          <= RESPOSTA;
                    respValido      <= 1'b1;
                    respDado        <= '0;
                    respErro        <= 1'b0;
                end
                LEITURA: begin
                    contador <= contador - 1'b1;
                    if (contador == CW'(1)) begin
                        lerMemoria <= 1'b0;
                        estado     <= RESPOSTA;
                        respValido <= 1'b1;
                        respDado   <= saida;
                        respErro   <= 1'b0;
                    end
                end
                RESPOSTA: begin
                    if (respAceito) begin
                        respValido <= 1'b0;
                        reqPronto  <= 1'b1;
                        estado     <= OCIOSO;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_controlador_memoria.sv
// tb_controlador_memoria: directed checks of two controllers (LATENCIA=1 and LATENCIA=3),
// each attached to a small behavioural memory.
module tb_controlador_memoria;
    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        val_a = 0, esc_a = 0, acc_a = 1;
    logic [31:0] end_a = 0, dado_a = 0, s_a;
    logic        pr_a, rv_a, re_a, ew_a, lr_a;
    logic [31:0] rd_a, me_a, mv_a;

    logic        val_b = 0, esc_b = 0, acc_b = 1;
    logic [31:0] end_b = 0, dado_b = 0, s_b;
    logic        pr_b, rv_b, re_b, ew_b, lr_b;
    logic [31:0] rd_b, me_b, mv_b;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    int          errors = 0, checks = 0;
    int          sobre = 0, strobes_a = 0;

    always #5 clock = ~clock;

    controlador_memoria #(.LATENCIA(1), .PROFUNDIDADE(256)) dut_a (
        .clock(clock), .reset(reset), .reqValido(val_a), .reqEscrita(esc_a),
        .reqEndereco(end_a), .reqDado(dado_a), .reqPronto(pr_a), .respValido(rv_a),
        .respAceito(acc_a), .respDado(rd_a), .respErro(re_a), .memEndereco(me_a),
        .memValor(mv_a), .escreverMemoria(ew_a), .lerMemoria(lr_a), .saida(s_a)
    );

    controlador_memoria #(.LATENCIA(3), .PROFUNDIDADE(256)) dut_b (
        .clock(clock), .reset(reset), .reqValido(val_b), .reqEscrita(esc_b),
        .reqEndereco(end_b), .reqDado(dado_b), .reqPronto(pr_b), .respValido(rv_b),
        .respAceito(acc_b), .respDado(rd_b), .respErro(re_b), .memEndereco(me_b),
        .memValor(mv_b), .escreverMemoria(ew_b), .lerMemoria(lr_b), .saida(s_b)
    );

    assign s_a = mem_a[me_a[7:0]];
    assign s_b = mem_b[me_b[7:0]];

    always @(posedge clock) begin
        if (ew_a) mem_a[me_a[7:0]] <= mv_a;
        if (ew_b) mem_b[me_b[7:0]] <= mv_b;
        if ((ew_a && lr_a) || (ew_b && lr_b)) sobre <= sobre + 1;
        if (ew_a || lr_a) strobes_a <= strobes_a + 1;
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: obtido=%0h esperado=%0h", tag, obs, exp);
        end
    endtask

    // one complete transaction on dut_a with respAceito held high
    task automatic transacao_a(input logic esc, input logic [31:0] addr, input logic [31:0] dado,
                               output logic [31:0] lido, output logic err, output int ciclos);
        esc_a = esc; end_a = addr; dado_a = dado; val_a = 1;
        step;
        val_a = 0;
        ciclos = 1;
        while (!rv_a && ciclos < 20) begin
            step;
            ciclos++;
        end
        check("resp_timeout", rv_a, 1);
        lido = rd_a;
        err = re_a;
        acc_a = 1;
        step;
        ciclos++;
    endtask

    initial begin
        logic [31:0] lido;
        logic        err;
        int          n, nl, s0;

        #1 reset = 0;
        step;
        step;
        check("reset_pronto", pr_a, 0);
        check("reset_valido", rv_a, 0);
        check("reset_dado", rd_a, 0);
        check("reset_mem_end", me_a, 0);
        check("reset_mem_val", mv_a, 0);
        check("reset_strobes", {ew_a, lr_a}, 0);
        reset = 1;
        step;
        check("pronto_pos_reset", pr_a, 1);

        // write addr 1 = 100, cycle by cycle
        esc_a = 1; end_a = 1; dado_a = 100; val_a = 1;
        step;
        val_a = 0;
        check("esc_strobe", ew_a, 1);
        check("esc_ler", lr_a, 0);
        check("esc_mem_end", me_a, 1);
        check("esc_mem_val", mv_a, 100);
        check("esc_pronto", pr_a, 0);
        step;
        check("esc_strobe_fim", ew_a, 0);
        check("esc_resp_valido", rv_a, 1);
        check("esc_resp_dado", rd_a, 0);
        check("esc_resp_erro", re_a, 0);
        step;
        check("esc_resp_fim", rv_a, 0);
        check("esc_pronto_volta", pr_a, 1);

        // read addr 1 back
        esc_a = 0; end_a = 1; val_a = 1;
        step;
        val_a = 0;
        check("ler_strobe", lr_a, 1);
        check("ler_esc", ew_a, 0);
        step;
        check("ler_strobe_fim", lr_a, 0);
        check("ler_resp_valido", rv_a, 1);
        check("ler_resp_dado", rd_a, 100);
        step;
        check("ler_pronto_volta", pr_a, 1);

        // out-of-range addresses never strobe
        s0 = strobes_a;
        transacao_a(0, 256, 0, lido, err, n);
        check("erro256_flag", err, 1);
        check("erro256_dado", lido, 0);
        check("erro256_ciclos", n, 2);
        transacao_a(1, 32'hFFFF_FFFF, 32'h1234, lido, err, n);
        check("erroFFFF_flag", err, 1);
        check("erroFFFF_dado", lido, 0);
        check("erro_sem_strobe", strobes_a, s0);
        transacao_a(0, 255, 0, lido, err, n);
        check("end255_valido", err, 0);

        // backpressure: response held, second request ignored
        transacao_a(1, 3, 32'h33, lido, err, n);
        acc_a = 0;
        esc_a = 0; end_a = 1; val_a = 1;
        step;
        val_a = 0;
        step;
        check("bp_valido_ini", rv_a, 1);
        esc_a = 1; end_a = 3; dado_a = 32'h55; val_a = 1;
        for (int i = 0; i < 5; i++) begin
            step;
            check("bp_valido", rv_a, 1);
            check("bp_dado", rd_a, 100);
            check("bp_pronto", pr_a, 0);
            check("bp_esc", ew_a, 0);
        end
        val_a = 0; acc_a = 1;
        step;
        check("bp_libera", rv_a, 0);
        check("bp_pronto_volta", pr_a, 1);
        transacao_a(0, 3, 0, lido, err, n);
        check("bp_nao_aceito", lido, 32'h33);

        // back-to-back alternating write/read
        for (int i = 0; i < 8; i++) begin
            transacao_a(1, i, 32'hA000 + i * 17, lido, err, n);
            check("b2b_esc_ciclos", n, 3);
            check("b2b_esc_erro", err, 0);
            transacao_a(0, i, 0, lido, err, n);
            check("b2b_ler_dado", lido, 32'hA000 + i * 17);
            check("b2b_ler_ciclos", n, 3);
        end

        // LATENCIA=3: store DEADBEEF at 5, then read it
        esc_b = 1; end_b = 5; dado_b = 32'hDEAD_BEEF; val_b = 1;
        step;
        val_b = 0;
        step;
        check("b_esc_valido", rv_b, 1);
        step;
        esc_b = 0; end_b = 5; val_b = 1;
        step;
        val_b = 0;
        n = 1; nl = 0;
        while (!rv_b && n < 20) begin
            if (lr_b) nl++;
            step;
            n++;
        end
        check("lat3_ler_ciclos", nl, 3);
        check("lat3_resp_ciclo", n, 4);
        check("lat3_ler_fim", lr_b, 0);
        check("lat3_dado", rd_b, 32'hDEAD_BEEF);
        step;
        check("lat3_pronto", pr_b, 1);

        // asynchronous reset in cycle 2 of a LATENCIA=3 read
        esc_b = 0; end_b = 5; val_b = 1;
        step;
        val_b = 0;
        step;
        check("rst_ler_ativo", lr_b, 1);
        #2 reset = 0;
        #1;
        check("rst_ler_cai", lr_b, 0);
        check("rst_pronto_cai", pr_b, 0);
        step;
        reset = 1;
        step;
        check("rst_pronto_volta", pr_b, 1);
        check("rst_mem_end", me_b, 0);
        check("rst_mem_val", mv_b, 0);
        check("rst_dado", rd_b, 0);
        check("rst_erro", re_b, 0);
        nl = 0;
        for (int i = 0; i < 6; i++) begin
            step;
            if (rv_b || lr_b || ew_b) nl++;
        end
        check("rst_sem_resposta", nl, 0);
        check("strobes_sobrepostos", sobre, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
